// File: rtl/id_stage_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : id_stage_pipe_if
// Brief  : Handshake/data bundle between if_id, the decode stage and ex.
// Rev    : 1.0  initial release
// ============================================================================
interface id_stage_pipe_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
);
    // upstream side
    logic                in_valid_i;
    logic                in_ready_o;
    logic [31:0]         inst_i;
    logic [XLEN-1:0]     inst_addr_i;
    // register file read port
    logic [RADDR_W-1:0]  rs1_addr_o;
    logic [RADDR_W-1:0]  rs2_addr_o;
    logic [XLEN-1:0]     rs1_data_i;
    logic [XLEN-1:0]     rs2_data_i;
    // control
    logic                flush_i;
    // downstream side
    logic                out_valid_o;
    logic                out_ready_i;
    logic [31:0]         inst_o;
    logic [XLEN-1:0]     inst_addr_o;
    logic [XLEN-1:0]     op1_o;
    logic [XLEN-1:0]     op2_o;
    logic [RADDR_W-1:0]  rd_addr_o;
    logic                reg_wen_o;
    logic [3:0]          alu_op_o;
    logic                illegal_o;
    logic [CNT_W-1:0]    dec_cnt_o;

    modport slave (
        input  in_valid_i, inst_i, inst_addr_i, rs1_data_i, rs2_data_i,
               flush_i, out_ready_i,
        output in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o, inst_o,
               inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o, alu_op_o,
               illegal_o, dec_cnt_o
    );

    modport master (
        output in_valid_i, inst_i, inst_addr_i, rs1_data_i, rs2_data_i,
               flush_i, out_ready_i,
        input  in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o, inst_o,
               inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o, alu_op_o,
               illegal_o, dec_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module : id_stage_pipe
// Brief  : RV32I integer decode merged with the ID/EX register (OP-IMM, OP,
//          LUI, AUIPC), valid/ready back-pressure, flush and decode counter.
// Rev    : 1.0  initial release
// ============================================================================
module id_stage_pipe #(
    parameter int          XLEN     = 32,
    parameter int          RADDR_W  = 5,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          CNT_W    = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    id_stage_pipe_if.slave  bus
);

    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_F7_BASE    = 7'b0000000;
    localparam logic [6:0] c_F7_ALT     = 7'b0100000;

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_SLL  = 4'd2;
    localparam logic [3:0] c_ALU_SLT  = 4'd3;
    localparam logic [3:0] c_ALU_SLTU = 4'd4;
    localparam logic [3:0] c_ALU_XOR  = 4'd5;
    localparam logic [3:0] c_ALU_SRL  = 4'd6;
    localparam logic [3:0] c_ALU_SRA  = 4'd7;
    localparam logic [3:0] c_ALU_OR   = 4'd8;
    localparam logic [3:0] c_ALU_AND  = 4'd9;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]          w_opcode;
    logic [2:0]          w_funct3;
    logic [6:0]          w_funct7;
    logic [RADDR_W-1:0]  w_rd_fld;
    logic [RADDR_W-1:0]  w_rs1_fld;
    logic [RADDR_W-1:0]  w_rs2_fld;
    logic [XLEN-1:0]     w_imm_i;
    logic [XLEN-1:0]     w_imm_u;
    logic [XLEN-1:0]     w_shamt;

    assign w_opcode  = bus.inst_i[6:0];
    assign w_funct3  = bus.inst_i[14:12];
    assign w_funct7  = bus.inst_i[31:25];
    assign w_rd_fld  = RADDR_W'(bus.inst_i[11:7]);
    assign w_rs1_fld = RADDR_W'(bus.inst_i[19:15]);
    assign w_rs2_fld = RADDR_W'(bus.inst_i[24:20]);
    assign w_imm_i   = XLEN'($signed(bus.inst_i[31:20]));
    assign w_imm_u   = XLEN'($signed({bus.inst_i[31:12], 12'b0}));
    assign w_shamt   = XLEN'(bus.inst_i[24:20]);

    // funct3 to ALU opcode for the base (funct7 = 0) register/immediate forms
    function automatic logic [3:0] f3_to_alu(input logic [2:0] f3);
        logic [3:0] alu;
        case (f3)
            3'b000:  alu = c_ALU_ADD;
            3'b001:  alu = c_ALU_SLL;
            3'b010:  alu = c_ALU_SLT;
            3'b011:  alu = c_ALU_SLTU;
            3'b100:  alu = c_ALU_XOR;
            3'b101:  alu = c_ALU_SRL;
            3'b110:  alu = c_ALU_OR;
            default: alu = c_ALU_AND;
        endcase
        return alu;
    endfunction

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                w_legal;
    logic                w_use_rs1;
    logic                w_use_rs2;
    logic [XLEN-1:0]     w_raw_op1;
    logic [XLEN-1:0]     w_raw_op2;
    logic [3:0]          w_raw_alu;

    always_comb begin
        w_legal   = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_raw_op1 = '0;
        w_raw_op2 = '0;
        w_raw_alu = c_ALU_ADD;
        case (w_opcode)
            c_OPC_OP_IMM: begin
                w_use_rs1 = 1'b1;
                w_raw_op1 = bus.rs1_data_i;
                case (w_funct3)
                    3'b001: begin
                        w_legal   = (w_funct7 == c_F7_BASE);
                        w_raw_alu = c_ALU_SLL;
                        w_raw_op2 = w_shamt;
                    end
                    3'b101: begin
                        w_legal   = (w_funct7 == c_F7_BASE) || (w_funct7 == c_F7_ALT);
                        w_raw_alu = (w_funct7 == c_F7_ALT) ? c_ALU_SRA : c_ALU_SRL;
                        w_raw_op2 = w_shamt;
                    end
                    default: begin
                        w_legal   = 1'b1;
                        w_raw_alu = f3_to_alu(w_funct3);
                        w_raw_op2 = w_imm_i;
                    end
                endcase
            end
            c_OPC_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_raw_op1 = bus.rs1_data_i;
                w_raw_op2 = bus.rs2_data_i;
                if (w_funct7 == c_F7_BASE) begin
                    w_legal   = 1'b1;
                    w_raw_alu = f3_to_alu(w_funct3);
                end else if (w_funct7 == c_F7_ALT && w_funct3 == 3'b000) begin
                    w_legal   = 1'b1;
                    w_raw_alu = c_ALU_SUB;
                end else if (w_funct7 == c_F7_ALT && w_funct3 == 3'b101) begin
                    w_legal   = 1'b1;
                    w_raw_alu = c_ALU_SRA;
                end
            end
            c_OPC_LUI: begin
                w_legal   = 1'b1;
                w_raw_op2 = w_imm_u;
            end
            c_OPC_AUIPC: begin
                w_legal   = 1'b1;
                w_raw_op1 = bus.inst_addr_i;
                w_raw_op2 = w_imm_u;
            end
            default: ;
        endcase
    end

    // Illegal encodings carry nothing that could reach the register file
    logic [XLEN-1:0]     w_dec_op1;
    logic [XLEN-1:0]     w_dec_op2;
    logic [3:0]          w_dec_alu;
    logic [RADDR_W-1:0]  w_dec_rd;
    logic                w_dec_wen;

    assign w_dec_op1 = w_legal ? w_raw_op1 : '0;
    assign w_dec_op2 = w_legal ? w_raw_op2 : '0;
    assign w_dec_alu = w_legal ? w_raw_alu : c_ALU_ADD;
    assign w_dec_rd  = w_legal ? w_rd_fld  : '0;
    assign w_dec_wen = w_legal && (w_rd_fld != '0);

    assign bus.rs1_addr_o = w_use_rs1 ? w_rs1_fld : '0;
    assign bus.rs2_addr_o = w_use_rs2 ? w_rs2_fld : '0;

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    logic                out_valid_q, out_valid_d;
    logic [31:0]         inst_q,      inst_d;
    logic [XLEN-1:0]     inst_addr_q, inst_addr_d;
    logic [XLEN-1:0]     op1_q,       op1_d;
    logic [XLEN-1:0]     op2_q,       op2_d;
    logic [RADDR_W-1:0]  rd_q,        rd_d;
    logic                reg_wen_q,   reg_wen_d;
    logic [3:0]          alu_op_q,    alu_op_d;
    logic                illegal_q,   illegal_d;
    logic [CNT_W-1:0]    dec_cnt_q,   dec_cnt_d;

    logic w_in_ready;
    logic w_accept;

    assign w_in_ready = !bus.flush_i && (!out_valid_q || bus.out_ready_i);
    assign w_accept   = bus.in_valid_i && w_in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        rd_d        = rd_q;
        reg_wen_d   = reg_wen_q;
        alu_op_d    = alu_op_q;
        illegal_d   = illegal_q;
        dec_cnt_d   = dec_cnt_q;
        if (bus.flush_i) begin
            out_valid_d = 1'b0;
            inst_d      = NOP_INST;
            reg_wen_d   = 1'b0;
        end else if (w_accept) begin
            out_valid_d = 1'b1;
            inst_d      = bus.inst_i;
            inst_addr_d = bus.inst_addr_i;
            op1_d       = w_dec_op1;
            op2_d       = w_dec_op2;
            rd_d        = w_dec_rd;
            reg_wen_d   = w_dec_wen;
            alu_op_d    = w_dec_alu;
            illegal_d   = !w_legal;
            dec_cnt_d   = dec_cnt_q + CNT_W'(1);
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            inst_q      <= NOP_INST;
            inst_addr_q <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            rd_q        <= '0;
            reg_wen_q   <= 1'b0;
            alu_op_q    <= c_ALU_ADD;
            illegal_q   <= 1'b0;
            dec_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            rd_q        <= rd_d;
            reg_wen_q   <= reg_wen_d;
            alu_op_q    <= alu_op_d;
            illegal_q   <= illegal_d;
            dec_cnt_q   <= dec_cnt_d;
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.inst_o      = inst_q;
    assign bus.inst_addr_o = inst_addr_q;
    assign bus.op1_o       = op1_q;
    assign bus.op2_o       = op2_q;
    assign bus.rd_addr_o   = rd_q;
    assign bus.reg_wen_o   = reg_wen_q;
    assign bus.alu_op_o    = alu_op_q;
    assign bus.illegal_o   = illegal_q;
    assign bus.dec_cnt_o   = dec_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_id_stage_pipe
// Brief  : Self-checking bench for id_stage_pipe against an instruction-level
//          reference model; a 3-bit-counter instance covers counter wrap.
// Rev    : 1.0  initial release
// ============================================================================
module tb_id_stage_pipe;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_w = 1'b1;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.XLEN(32), .RADDR_W(5), .CNT_W(32)) bus ();
    id_stage_pipe_if #(.XLEN(32), .RADDR_W(5), .CNT_W(3))  bus_w ();

    id_stage_pipe #(.XLEN(32), .RADDR_W(5), .NOP_INST(c_NOP), .CNT_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    id_stage_pipe #(.XLEN(32), .RADDR_W(5), .NOP_INST(c_NOP), .CNT_W(3)) u_dut_w (
        .clk (clk),
        .rst (rst_w),
        .bus (bus_w)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: the single held ID/EX entry
    logic        m_valid;
    logic [31:0] m_inst, m_addr, m_op1, m_op2, m_cnt;
    logic [4:0]  m_rd;
    logic        m_wen, m_ill;
    logic [3:0]  m_alu;

    // Instruction-level decode straight from the ISA rules
    task automatic ref_dec(input logic [31:0] inst, input logic [31:0] pc,
                           input logic [31:0] d1, input logic [31:0] d2,
                           output logic [31:0] op1, output logic [31:0] op2,
                           output logic [4:0] rd, output logic wen,
                           output logic [3:0] alu, output logic ill,
                           output logic [4:0] rs1a, output logic [4:0] rs2a);
        int alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic ok;
        opc = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
        ok = 1'b0; op1 = 0; op2 = 0; alu = 0; rs1a = 0; rs2a = 0;
        if (opc == 7'h13) begin
            rs1a = inst[19:15]; op1 = d1;
            if (f3 == 3'd1) begin
                ok = (f7 == 7'h00); alu = 4'd2; op2 = {27'b0, inst[24:20]};
            end else if (f3 == 3'd5) begin
                ok = (f7 == 7'h00) || (f7 == 7'h20);
                alu = (f7 == 7'h20) ? 4'd7 : 4'd6; op2 = {27'b0, inst[24:20]};
            end else begin
                ok = 1'b1; alu = 4'(alu_tab[f3]); op2 = {{20{inst[31]}}, inst[31:20]};
            end
        end else if (opc == 7'h33) begin
            rs1a = inst[19:15]; rs2a = inst[24:20]; op1 = d1; op2 = d2;
            if (f7 == 7'h00) begin ok = 1'b1; alu = 4'(alu_tab[f3]); end
            else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; alu = 4'd1; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; alu = 4'd7; end
        end else if (opc == 7'h37) begin
            ok = 1'b1; op1 = 0; op2 = {inst[31:12], 12'b0};
        end else if (opc == 7'h17) begin
            ok = 1'b1; op1 = pc; op2 = {inst[31:12], 12'b0};
        end
        ill = !ok;
        rd  = ok ? inst[11:7] : 5'd0;
        wen = ok && (inst[11:7] != 5'd0);
        if (!ok) begin op1 = 0; op2 = 0; alu = 0; end
    endtask

    task automatic model_edge();
        logic [31:0] o1, o2;
        logic [4:0]  rd, a1, a2;
        logic        wen, ill;
        logic [3:0]  alu;
        if (rst) begin
            m_valid = 0; m_inst = c_NOP; m_addr = 0; m_op1 = 0; m_op2 = 0;
            m_rd = 0; m_wen = 0; m_alu = 0; m_ill = 0; m_cnt = 0;
        end else if (bus.flush_i) begin
            m_valid = 0; m_inst = c_NOP; m_wen = 0;
        end else if (bus.in_valid_i && (!m_valid || bus.out_ready_i)) begin
            ref_dec(bus.inst_i, bus.inst_addr_i, bus.rs1_data_i, bus.rs2_data_i,
                    o1, o2, rd, wen, alu, ill, a1, a2);
            m_valid = 1; m_inst = bus.inst_i; m_addr = bus.inst_addr_i;
            m_op1 = o1; m_op2 = o2; m_rd = rd; m_wen = wen; m_alu = alu; m_ill = ill;
            m_cnt = m_cnt + 1;
        end else if (bus.out_ready_i) begin
            m_valid = 0;
        end
    endtask

    function automatic logic [171:0] m_snap();
        return {m_valid, m_inst, m_addr, m_op1, m_op2, m_rd, m_wen, m_alu, m_ill, m_cnt};
    endfunction

    function automatic logic [171:0] d_snap();
        return {bus.out_valid_o, bus.inst_o, bus.inst_addr_o, bus.op1_o, bus.op2_o,
                bus.rd_addr_o, bus.reg_wen_o, bus.alu_op_o, bus.illegal_o, bus.dec_cnt_o};
    endfunction

    function automatic logic m_ready();
        return !bus.flush_i && (!m_valid || bus.out_ready_i);
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic fl, input logic ordy);
        bus.in_valid_i = v;   bus.inst_i = inst;   bus.inst_addr_i = pc;
        bus.rs1_data_i = d1;  bus.rs2_data_i = d2; bus.flush_i = fl;
        bus.out_ready_i = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        logic [6:0]  f7;
        r = $urandom();
        case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'($urandom());
        endcase
        case ($urandom_range(0, 5))
            0: begin r[6:0] = 7'h13; r[31:25] = f7; end
            1: begin r[6:0] = 7'h33; r[31:25] = f7; end
            2: r[6:0] = 7'h37;
            3: r[6:0] = 7'h17;
            4: r[6:0] = 7'h13;
            default: ;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        drive(0, 32'h0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (d_snap() !== m_snap()) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", d_snap(), m_snap());
        end
        n_tests++;
        if ({bus.out_valid_o, bus.inst_o, bus.dec_cnt_o, bus.in_ready_o} !== {1'b0, c_NOP, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_const: got v=%b inst=%h cnt=%h rdy=%b expected v=0 inst=00000013 cnt=0 rdy=1",
                     bus.out_valid_o, bus.inst_o, bus.dec_cnt_o, bus.in_ready_o);
        end
    endtask

    task automatic test_addi();
        drive(1, 32'hfff08293, 32'h40, 32'd10, 32'h5a5a, 0, 1);
        #1;
        n_tests++;
        if ({bus.rs1_addr_o, bus.rs2_addr_o, bus.in_ready_o} !== {5'd1, 5'd0, 1'b1}) begin
            n_fail++; $display("FAIL addi_rsaddr: got rs1=%0d rs2=%0d rdy=%b expected 1 0 1",
                               bus.rs1_addr_o, bus.rs2_addr_o, bus.in_ready_o);
        end
        tick();
        n_tests++;
        if ({bus.out_valid_o, bus.op1_o, bus.op2_o, bus.rd_addr_o, bus.reg_wen_o, bus.alu_op_o, bus.illegal_o}
            !== {1'b1, 32'd10, 32'hffffffff, 5'd5, 1'b1, 4'd0, 1'b0}) begin
            n_fail++; $display("FAIL addi_fields: got op1=%h op2=%h rd=%0d wen=%b alu=%0d expected 0000000a ffffffff 5 1 0",
                               bus.op1_o, bus.op2_o, bus.rd_addr_o, bus.reg_wen_o, bus.alu_op_o);
        end
    endtask

    task automatic test_stall();
        drive(1, 32'h402081b3, 32'h44, 32'd7, 32'd3, 0, 1);
        #1;
        n_tests++;
        if ({bus.rs1_addr_o, bus.rs2_addr_o} !== {5'd1, 5'd2}) begin
            n_fail++; $display("FAIL sub_rsaddr: got %0d %0d expected 1 2", bus.rs1_addr_o, bus.rs2_addr_o);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, gen_inst(), $urandom(), $urandom(), $urandom(), 0, 0);
            #1;
            n_tests++;
            if (bus.in_ready_o !== 1'b0) begin
                n_fail++; $display("FAIL stall_ready: got %b expected 0", bus.in_ready_o);
            end
            tick();
            n_tests++;
            if ({bus.out_valid_o, bus.op1_o, bus.op2_o, bus.rd_addr_o, bus.alu_op_o, bus.dec_cnt_o}
                !== {1'b1, 32'd7, 32'd3, 5'd3, 4'd1, 32'd2} || d_snap() !== m_snap()) begin
                n_fail++; $display("FAIL stall_hold: got %h expected %h", d_snap(), m_snap());
            end
        end
    endtask

    task automatic test_auipc_srai();
        drive(1, 32'h12345397, 32'h100, 32'hdead, 32'hbeef, 0, 1);
        #1;
        n_tests++;
        if ({bus.rs1_addr_o, bus.rs2_addr_o} !== 10'd0) begin
            n_fail++; $display("FAIL auipc_rsaddr: got %0d %0d expected 0 0", bus.rs1_addr_o, bus.rs2_addr_o);
        end
        tick();
        n_tests++;
        if ({bus.op1_o, bus.op2_o, bus.rd_addr_o, bus.reg_wen_o, bus.alu_op_o}
            !== {32'h100, 32'h12345000, 5'd7, 1'b1, 4'd0}) begin
            n_fail++; $display("FAIL auipc: got op1=%h op2=%h rd=%0d alu=%0d expected 00000100 12345000 7 0",
                               bus.op1_o, bus.op2_o, bus.rd_addr_o, bus.alu_op_o);
        end
        drive(1, 32'h4030d213, 32'h104, 32'h80000000, 32'h0, 0, 1);
        tick();
        n_tests++;
        if ({bus.alu_op_o, bus.op1_o, bus.op2_o, bus.rd_addr_o, bus.illegal_o}
            !== {4'd7, 32'h80000000, 32'd3, 5'd4, 1'b0}) begin
            n_fail++; $display("FAIL srai: got alu=%0d op2=%h rd=%0d ill=%b expected 7 00000003 4 0",
                               bus.alu_op_o, bus.op2_o, bus.rd_addr_o, bus.illegal_o);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] insts [3] = '{32'h00002003, 32'h40309293, 32'h00508013};
        logic [3:0]  want  [3] = '{4'b1100, 4'b1100, 4'b0100};
        for (int i = 0; i < 3; i++) begin
            drive(1, insts[i], 32'h200 + 32'(i * 4), 32'h11, 32'h22, 0, 1);
            tick();
            n_tests++;
            if ({bus.illegal_o, bus.out_valid_o, bus.reg_wen_o, (bus.rd_addr_o != 5'd0)} !== want[i]
                || d_snap() !== m_snap()) begin
                n_fail++; $display("FAIL illegal_%0d: got ill/v/wen/rdnz=%b expected %b", i,
                                   {bus.illegal_o, bus.out_valid_o, bus.reg_wen_o, (bus.rd_addr_o != 5'd0)}, want[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] cnt0;
        drive(1, 32'h00a00093, 32'h300, 0, 0, 0, 0);
        tick();
        drive(0, 32'h0, 0, 0, 0, 0, 0);
        tick();
        cnt0 = m_cnt;
        drive(1, 32'h00100113, 32'h304, 0, 0, 1, 1);
        #1;
        n_tests++;
        if (bus.in_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_ready: got %b expected 0", bus.in_ready_o);
        end
        tick();
        n_tests++;
        if ({bus.out_valid_o, bus.inst_o, bus.reg_wen_o, bus.dec_cnt_o} !== {1'b0, c_NOP, 1'b0, cnt0}) begin
            n_fail++; $display("FAIL flush: got v=%b inst=%h wen=%b cnt=%h expected 0 00000013 0 %h",
                               bus.out_valid_o, bus.inst_o, bus.reg_wen_o, bus.dec_cnt_o, cnt0);
        end
    endtask

    task automatic test_rst_mid_stall();
        drive(1, 32'h00500293, 32'h400, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        drive(1, 32'h00600313, 32'h404, 0, 0, 1, 0);
        tick();
        rst = 1'b0;
        n_tests++;
        if ({bus.out_valid_o, bus.dec_cnt_o, bus.inst_o} !== {1'b0, 32'd0, c_NOP} || d_snap() !== m_snap()) begin
            n_fail++; $display("FAIL rst_mid_stall: got %h expected %h", d_snap(), m_snap());
        end
    endtask

    task automatic test_random();
        logic [31:0] o1, o2;
        logic [4:0]  rd, a1, a2;
        logic        wen, ill;
        logic [3:0]  alu;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), gen_inst(), $urandom(), $urandom(), $urandom(),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
            #1;
            ref_dec(bus.inst_i, bus.inst_addr_i, bus.rs1_data_i, bus.rs2_data_i,
                    o1, o2, rd, wen, alu, ill, a1, a2);
            n_tests++;
            if ({bus.rs1_addr_o, bus.rs2_addr_o, bus.in_ready_o} !== {a1, a2, m_ready()}) begin
                n_fail++; $display("FAIL rand_comb[%0d]: got rs1=%0d rs2=%0d rdy=%b expected %0d %0d %b",
                                   i, bus.rs1_addr_o, bus.rs2_addr_o, bus.in_ready_o, a1, a2, m_ready());
            end
            tick();
            n_tests++;
            if (d_snap() !== m_snap()) begin
                n_fail++; $display("FAIL rand_reg[%0d]: got %h expected %h", i, d_snap(), m_snap());
            end
        end
    endtask

    task automatic test_wrap();
        int exp_cnt;
        rst_w = 1'b1;
        tick();
        rst_w = 1'b0;
        exp_cnt = 0;
        bus_w.in_valid_i = 1'b1; bus_w.out_ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus_w.inst_i = 32'h00108093;
            tick();
            exp_cnt = (exp_cnt + 1) % 8;
            n_tests++;
            if (bus_w.dec_cnt_o !== 3'(exp_cnt)) begin
                n_fail++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", i, bus_w.dec_cnt_o, exp_cnt);
            end
        end
        bus_w.flush_i = 1'b1;
        tick();
        bus_w.flush_i = 1'b0;
        n_tests++;
        if ({bus_w.dec_cnt_o, bus_w.out_valid_o} !== {3'(exp_cnt), 1'b0}) begin
            n_fail++; $display("FAIL wrap_flush: got cnt=%0d v=%b expected %0d 0",
                               bus_w.dec_cnt_o, bus_w.out_valid_o, exp_cnt);
        end
    endtask

    initial begin
        drive(0, 32'h0, 0, 0, 0, 0, 0);
        bus_w.in_valid_i = 0; bus_w.inst_i = 0; bus_w.inst_addr_i = 0;
        bus_w.rs1_data_i = 0; bus_w.rs2_data_i = 0; bus_w.flush_i = 0; bus_w.out_ready_i = 0;
        #1;
        test_reset();
        test_addi();
        test_stall();
        test_auipc_srai();
        test_illegal();
        test_flush();
        test_rst_mid_stall();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
